reg_file: RTL and testbench

- Parametrised multi-entry successor to the single enabled register.
- Holds DEPTH words of WIDTH bits, with one synchronous write port and two asynchronous read ports.
- Serves as the general-purpose register file of the lab datapath.
- Adds synchronous clear and an optional hardwired-zero entry 0.

---
 rtl/reg_file.sv | 87 ++++++++
 tb/tb_reg_file.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: general-purpose register file for the lab datapath.
// DEPTH = 2**ADDR entries of WIDTH bits, one synchronous write port and two
// combinational read ports. The clear is synchronous and active-high.
// ZERO_REG=1 hardwires entry 0 to zero and makes it ignore writes.
// Optional macro REG_FILE_BYPASS_EN adds write-through forwarding on both read
// ports. Without the macro, the read ports show only the stored contents.
module reg_file #(
  parameter int WIDTH    = 32,
  parameter int ADDR     = 5,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [ADDR-1:0]  wn,
  input  logic [WIDTH-1:0] wd,
  input  logic [ADDR-1:0]  rn1,
  input  logic [ADDR-1:0]  rn2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  localparam int DEPTH = 2 ** ADDR;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;

  // Next contents: copy the array, then replace the addressed entry when
  // writing. An unknown wn never compares equal, so no entry is written.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (wn == ADDR'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
        mem_d[i] = wd;
      end
    end
  end

  // Storage register: a synchronous clear wins over any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Stored values for each read port, with entry 0 forced to zero when it is hardwired.
  always_comb begin
    stored1 = mem_q[rn1];
    stored2 = mem_q[rn2];
    if ((ZERO_REG != 0) && (rn1 == '0)) begin
      stored1 = '0;
    end
    if ((ZERO_REG != 0) && (rn2 == '0)) begin
      stored2 = '0;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic fwd1;
  logic fwd2;
  logic wr_live;

  // Forwarding: a write about to land on the addressed entry shows up immediately,
  // unless a clear is pending or the target is the hardwired zero entry.
  always_comb begin
    wr_live = we && !reset && ((ZERO_REG == 0) || (wn != '0));
    fwd1    = wr_live && (rn1 == wn);
    fwd2    = wr_live && (rn2 == wn);
    rd1     = fwd1 ? wd : stored1;
    rd2     = fwd2 ? wd : stored2;
  end
`else
  // Read ports show stored contents only; a same-cycle write appears after the edge.
  always_comb begin
    rd1 = stored1;
    rd2 = stored2;
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file.
// Two instances share every input: one has a hardwired zero entry, the other
// does not. Expected reads come from plain array models. The macro
// REG_FILE_BYPASS_EN, when defined, also switches on the forwarding rule in the model.
module tb_reg_file;

  localparam int WIDTH = 32;
  localparam int ADDR  = 5;
  localparam int DEPTH = 32;

  logic             clk;
  logic             reset;
  logic             we;
  logic [ADDR-1:0]  wn;
  logic [WIDTH-1:0] wd;
  logic [ADDR-1:0]  rn1;
  logic [ADDR-1:0]  rn2;
  logic [WIDTH-1:0] rd1_z;
  logic [WIDTH-1:0] rd2_z;
  logic [WIDTH-1:0] rd1_n;
  logic [WIDTH-1:0] rd2_n;

  int checks = 0;
  int errors = 0;

  // Reference contents: model_z for the ZERO_REG=1 instance, model_n for ZERO_REG=0.
  logic [WIDTH-1:0] model_z [DEPTH];
  logic [WIDTH-1:0] model_n [DEPTH];

  reg_file #(.WIDTH(WIDTH), .ADDR(ADDR), .ZERO_REG(1)) u_zero (
    .clk(clk), .reset(reset), .we(we), .wn(wn), .wd(wd),
    .rn1(rn1), .rn2(rn2), .rd1(rd1_z), .rd2(rd2_z)
  );

  reg_file #(.WIDTH(WIDTH), .ADDR(ADDR), .ZERO_REG(0)) u_plain (
    .clk(clk), .reset(reset), .we(we), .wn(wn), .wd(wd),
    .rn1(rn1), .rn2(rn2), .rd1(rd1_n), .rd2(rd2_n)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected read for one instance, given the current inputs.
  function automatic logic [WIDTH-1:0] expRead(input bit zero_reg, input logic [ADDR-1:0] rn);
    logic [WIDTH-1:0] v;
    if (zero_reg) v = (rn == 0) ? '0 : model_z[rn];
    else          v = model_n[rn];
`ifdef REG_FILE_BYPASS_EN
    if (we && !reset && (rn == wn) && (!zero_reg || wn != 0)) v = wd;
`endif
    return v;
  endfunction

  // Apply what a rising edge does to the models: clear everything, or store one word.
  task automatic modelEdge();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        model_z[i] = '0;
        model_n[i] = '0;
      end
    end else if (we) begin
      if (wn != 0) model_z[wn] = wd;
      model_n[wn] = wd;
    end
  endtask

  task automatic checkOne(input string tag, input string port, input logic [WIDTH-1:0] obs,
                          input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s %s observed=%h expected=%h", tag, port, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne(tag, "rd1_z", rd1_z, expRead(1'b1, rn1));
    checkOne(tag, "rd2_z", rd2_z, expRead(1'b1, rn2));
    checkOne(tag, "rd1_n", rd1_n, expRead(1'b0, rn1));
    checkOne(tag, "rd2_n", rd2_n, expRead(1'b0, rn2));
  endtask

  // Drive one set of inputs just after a falling edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [ADDR-1:0] n,
                               input logic [WIDTH-1:0] d, input logic [ADDR-1:0] a1,
                               input logic [ADDR-1:0] a2);
    @(negedge clk);
    reset = r;
    we    = w;
    wn    = n;
    wd    = d;
    rn1   = a1;
    rn2   = a2;
  endtask

  // One full cycle: check before the edge, update the models at the edge, check after it.
  task automatic cycle(input string tag, input logic r, input logic w, input logic [ADDR-1:0] n,
                       input logic [WIDTH-1:0] d, input logic [ADDR-1:0] a1,
                       input logic [ADDR-1:0] a2, input bit check);
    applyStimulus(r, w, n, d, a1, a2);
    #1;
    if (check) checkOutput({tag, "/pre"});
    @(posedge clk);
    modelEdge();
    #1;
    if (check) checkOutput({tag, "/post"});
  endtask

  // Read-only step with no write and no clear; intervening edges change nothing.
  task automatic readCheck(input string tag, input logic [ADDR-1:0] a1, input logic [ADDR-1:0] a2);
    applyStimulus(1'b0, 1'b0, '0, '0, a1, a2);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [ADDR-1:0] rw;
    logic [ADDR-1:0] ra;
    logic [ADDR-1:0] rb;
    logic [WIDTH-1:0] rdv;
    logic rwe;

    reset = 1'b0; we = 1'b0; wn = '0; wd = '0; rn1 = '0; rn2 = '0;

    // Bring the array to a known state, then fill it with random words.
    cycle("init", 1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle("fill", 1'b0, 1'b1, ADDR'(i), WIDTH'($urandom), ADDR'(i), ADDR'(DEPTH - 1 - i), 1'b0);
    end
    checkOutput("filled");

    // A clear edge with random contents present, then every address on both ports reads 0.
    cycle("reset", 1'b1, 1'b0, '0, '0, 5'd9, 5'd17, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      readCheck("reset_read", ADDR'(i), ADDR'(DEPTH - 1 - i));
    end

    // Basic write and readback, then hold with we=0 for three edges.
    cycle("wr5", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd31, 1'b1);
    cycle("wr31", 1'b0, 1'b1, 5'd31, 32'h00000064, 5'd5, 5'd31, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle("hold", 1'b0, 1'b0, 5'd5, 32'h12345678, 5'd5, 5'd31, 1'b1);
    end

    // Writes to entry 0: dropped for the hardwired instance, stored for the other.
    cycle("wr0", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1);
    readCheck("rd0", 5'd0, 5'd5);

    // Read and write the same entry in one cycle.
    cycle("col_setup", 1'b0, 1'b1, 5'd7, 32'h00000011, 5'd7, 5'd7, 1'b1);
    cycle("collision", 1'b0, 1'b1, 5'd7, 32'h00000022, 5'd7, 5'd7, 1'b1);
    readCheck("col_after", 5'd7, 5'd7);

    // Clear and write in one cycle: the clear wins, and nothing is forwarded.
    cycle("rw_setup", 1'b0, 1'b1, 5'd3, 32'h00000033, 5'd3, 5'd3, 1'b1);
    cycle("rst_vs_wr", 1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd5, 1'b1);
    readCheck("rst_vs_wr_after", 5'd3, 5'd7);

    // Random writes and reads checked against the models every cycle.
    for (int i = 0; i < 40; i++) begin
      rw  = ADDR'($urandom);
      ra  = (i % 4 == 0) ? rw : ADDR'($urandom);
      rb  = ADDR'($urandom);
      rdv = WIDTH'($urandom % 100);
      rwe = (i % 3 != 2);
      cycle("random", 1'b0, rwe, rw, rdv, ra, rb, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
